// File: rtl/ysyx_24090018_sb_regfile.sv
// Scoreboarded register file: NREG x DATA_WIDTH registers with a pending (busy) bit
// per register, combinational read ports with optional write-to-read forwarding.
module ysyx_24090018_sb_regfile #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int NREAD          = 2,
  parameter int BYPASS         = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen_i,
  input  logic [REG_ADDR_WIDTH-1:0]        waddr_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic                             alloc_i,
  input  logic [REG_ADDR_WIDTH-1:0]        alloc_addr_i,
  input  logic                             flush_i,
  input  logic [NREAD*REG_ADDR_WIDTH-1:0]  raddr_i,
  output logic [NREAD*DATA_WIDTH-1:0]      rdata_o,
  output logic [NREAD-1:0]                 rbusy_o,
  output logic [REG_ADDR_WIDTH:0]          pending_cnt_o,
  output logic                             any_busy_o
);

  localparam int NREG  = 2 ** REG_ADDR_WIDTH;
  localparam int CNT_W = REG_ADDR_WIDTH + 1;
  localparam bit BYP   = (BYPASS != 0);

  // Handshake: wen_i/alloc_i/flush_i are single-cycle qualifiers with no back-pressure;
  // each is consumed at the rising edge where it is high. Address 0 is never a target.
  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;

  logic wr_ok;
  logic al_ok;

  assign wr_ok = wen_i && (waddr_i != '0);
  assign al_ok = alloc_i && (alloc_addr_i != '0);

  // Writeback clears first so a same-address alloc wins; flush overrides allocs only.
  always_comb begin
    busy_next = busy;
    if (wr_ok) begin
      busy_next[waddr_i] = 1'b0;
    end
    if (flush_i) begin
      busy_next = '0;
    end else if (al_ok) begin
      busy_next[alloc_addr_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // The counter tracks the popcount of the next busy vector so it lands on the same edge.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_next = cnt_next + CNT_W'(busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_next;
      cnt  <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  assign pending_cnt_o = cnt;
  assign any_busy_o    = (cnt != '0);

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0]     rd;
    logic                      rb;

    assign ra = raddr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

    always_comb begin
      rd = regs[ra];
      rb = busy[ra];
      if (ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end else if (BYP && wr_ok && (waddr_i == ra)) begin
        rd = wdata_i;
        rb = 1'b0;
      end
    end

    assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy_o[k]                          = rb;
  end

endmodule

// File: tb/tb_ysyx_24090018_sb_regfile.sv
// Bench for the scoreboarded register file: directed vector table plus random
// traffic checked against an array-based model, on BYPASS=1 and BYPASS=0 instances.
module tb_ysyx_24090018_sb_regfile;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NREG = 16;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, wen, alloc, flush;
  logic [AW-1:0]     waddr, alloc_addr;
  logic [DW-1:0]     wdata;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata, rdata_nb;
  logic [NR-1:0]     rbusy, rbusy_nb;
  logic [AW:0]       cnt, cnt_nb;
  logic              any_busy, any_busy_nb;

  ysyx_24090018_sb_regfile #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr), .flush_i(flush), .raddr_i(raddr),
    .rdata_o(rdata), .rbusy_o(rbusy), .pending_cnt_o(cnt), .any_busy_o(any_busy)
  );

  ysyx_24090018_sb_regfile #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr), .flush_i(flush), .raddr_i(raddr),
    .rdata_o(rdata_nb), .rbusy_o(rbusy_nb), .pending_cnt_o(cnt_nb), .any_busy_o(any_busy_nb)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_data [NREG];
  bit            m_busy [NREG];
  bit            model_valid = 1'b0;

  function automatic logic [DW-1:0] exp_rd(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && wen && waddr != 0 && int'(waddr) == a) return wdata;
    return m_data[a];
  endfunction

  function automatic bit exp_rb(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wen && waddr != 0 && int'(waddr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int n = 0;
    foreach (m_busy[i]) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_update();
    if (rst) begin
      foreach (m_data[i]) begin
        m_data[i] = '0;
        m_busy[i] = 1'b0;
      end
      model_valid = 1'b1;
    end else begin
      if (wen && waddr != 0) begin
        m_data[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (flush) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else if (alloc && alloc_addr != 0) begin
        m_busy[alloc_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < NR; k++) begin
      int a;
      a = int'(raddr[k*AW +: AW]);
      chk($sformatf("model_rdata%0d", k), 64'(rdata[k*DW +: DW]), 64'(exp_rd(a, 1'b1)));
      chk($sformatf("model_rbusy%0d", k), 64'(rbusy[k]), 64'(exp_rb(a, 1'b1)));
      chk($sformatf("model_nb_rdata%0d", k), 64'(rdata_nb[k*DW +: DW]), 64'(exp_rd(a, 1'b0)));
      chk($sformatf("model_nb_rbusy%0d", k), 64'(rbusy_nb[k]), 64'(exp_rb(a, 1'b0)));
    end
    chk("model_cnt", 64'(cnt), 64'(m_count()));
    chk("model_cnt_nb", 64'(cnt_nb), 64'(m_count()));
    chk("model_any_busy", 64'(any_busy), 64'(m_count() != 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    if (model_valid) check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic          rst, wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          alloc;
    logic [AW-1:0] aaddr;
    logic          flush;
    logic [AW-1:0] ra0, ra1;
    logic          chk_en;
    logic [DW-1:0] d0, d1;
    logic [1:0]    busy;
    logic [AW:0]   cnt;
    logic [DW-1:0] nb0;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit w, input int wa, input logic [DW-1:0] wd,
                              input bit al, input int aa, input bit fl, input int r0, input int r1,
                              input bit c, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input int b, input int n, input logic [DW-1:0] nb0);
    vec_t v;
    v.rst = r; v.wen = w; v.waddr = AW'(wa); v.wdata = wd;
    v.alloc = al; v.aaddr = AW'(aa); v.flush = fl;
    v.ra0 = AW'(r0); v.ra1 = AW'(r1); v.chk_en = c;
    v.d0 = d0; v.d1 = d1; v.busy = 2'(b); v.cnt = (AW+1)'(n); v.nb0 = nb0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; wen = v.wen; waddr = v.waddr; wdata = v.wdata;
    alloc = v.alloc; alloc_addr = v.aaddr; flush = v.flush;
    raddr = {v.ra1, v.ra0};
  endtask

  vec_t vecs[$];

  initial begin
    //          rst wen wa wdata         al aa fl ra0 ra1 chk d0            d1            busy cnt nb0
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 5, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 1, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 5, 0, 1, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 3, 32'h12345678, 0, 0, 0, 3, 3, 1, 32'h12345678, 32'h12345678, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 7, 0, 7, 3, 1, 32'h0,        32'h12345678, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 7, 3, 1, 32'h0,        32'h12345678, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 7, 32'hAA,       0, 0, 0, 7, 0, 1, 32'hAA,       32'h0,        0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 7, 0, 1, 32'hAA,       32'h0,        0, 0, 32'hAA));
    vecs.push_back(mk(0, 1, 9, 32'h99,       1, 9, 0, 9, 9, 1, 32'h99,       32'h99,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 9, 0, 1, 32'h99,       32'h0,        1, 1, 32'h99));
    vecs.push_back(mk(0, 1, 9, 32'h55,       1, 1, 0, 9, 1, 1, 32'h55,       32'h0,        0, 1, 32'h99));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 2, 0, 9, 1, 1, 32'h55,       32'h0,        2, 1, 32'h55));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 0, 1, 2, 1, 32'h0,        32'h0,        3, 2, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 4, 1, 2, 4, 1, 32'h0,        32'h0,        1, 2, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 2, 4, 1, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 6, 32'h5,        1, 2, 0, 6, 2, 1, 32'h5,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 6, 2, 1, 32'h5,        32'h0,        2, 1, 32'h5));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 6, 5, 1, 32'h0,        32'h0,        0, 0, 32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      sample();
      if (vecs[i].chk_en) begin
        chk($sformatf("tbl%0d_rdata0", i), 64'(rdata[0 +: DW]), 64'(vecs[i].d0));
        chk($sformatf("tbl%0d_rdata1", i), 64'(rdata[DW +: DW]), 64'(vecs[i].d1));
        chk($sformatf("tbl%0d_rbusy", i), 64'(rbusy), 64'(vecs[i].busy));
        chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(vecs[i].cnt));
        chk($sformatf("tbl%0d_any_busy", i), 64'(any_busy), 64'(vecs[i].cnt != 0));
        chk($sformatf("tbl%0d_nb_rdata0", i), 64'(rdata_nb[0 +: DW]), 64'(vecs[i].nb0));
      end
      tick();
    end

    // Mid-operation reset with several pending allocs drops everything in one edge.
    drive(mk(0, 0, 0, 32'h0, 1, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    sample(); tick();
    drive(mk(0, 1, 8, 32'hCAFE, 1, 11, 0, 3, 11, 0, 0, 0, 0, 0, 0));
    sample(); tick();
    drive(mk(1, 1, 12, 32'h77, 1, 13, 0, 3, 8, 0, 0, 0, 0, 0, 0));
    sample();
    chk("seq_pre_rst_cnt", 64'(cnt), 64'd2);
    tick();
    drive(mk(0, 0, 0, 32'h0, 0, 0, 0, 12, 8, 0, 0, 0, 0, 0, 0));
    sample();
    chk("seq_rst_cnt", 64'(cnt), 64'd0);
    chk("seq_rst_data", 64'(rdata), 64'd0);
    chk("seq_rst_any_busy", 64'(any_busy), 64'd0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      wen        = 1'($urandom_range(0, 1));
      waddr      = AW'($urandom_range(0, NREG - 1));
      wdata      = $urandom;
      alloc      = 1'($urandom_range(0, 1));
      alloc_addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREG - 1));
      flush      = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NR; k++) begin
        raddr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, NREG - 1));
      end
      sample();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24090018_sb_regfile.md
YSYX_24090018_SB_REGFILE -- requirements
Module: ysyx_24090018_sb_regfile

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 4, meaning register address width; NREG = 2**REG_ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-003 SHALL have parameter NREAD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 wen_i  in  1  writeback valid.
REQ-009 waddr_i  in  REG_ADDR_WIDTH  writeback address.
REQ-010 wdata_i  in  DATA_WIDTH  writeback data.
REQ-011 alloc_i  in  1  issue marks a destination as pending.
REQ-012 alloc_addr_i  in  REG_ADDR_WIDTH  destination being allocated.
REQ-013 flush_i  in  1  clear all pending marks.
REQ-014 raddr_i  in  NREAD*REG_ADDR_WIDTH  packed read addresses; port k is at bits [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
REQ-015 rdata_o  out  NREAD*DATA_WIDTH  packed read data, same packing.
REQ-016 rbusy_o  out  NREAD  port k reads a pending register.
REQ-017 pending_cnt_o  out  REG_ADDR_WIDTH+1  count of pending registers.
REQ-018 any_busy_o  out  1  pending_cnt_o != 0.

Function
REQ-019 SHALL hold NREG registers of DATA_WIDTH bits and one busy bit per register.
REQ-020 Register 0 SHALL always read 0 and never be busy; writes and allocs to address 0 are ignored.
REQ-021 When wen_i=1 and waddr_i!=0, SHALL write wdata_i to waddr_i at the clock edge and clear its busy bit.
REQ-022 When alloc_i=1 and alloc_addr_i!=0, SHALL set busy[alloc_addr_i] at the clock edge.
REQ-023 When alloc and writeback target the same address in one cycle, data SHALL be written and busy SHALL end at 1 (alloc wins).
REQ-024 flush_i=1 SHALL clear all busy bits at the edge and take priority over a same-cycle alloc_i; a same-cycle data write SHALL still complete.
REQ-025 Reads SHALL be combinational (0-cycle latency) from the register array.
REQ-026 If BYPASS=1 and wen_i=1 and waddr_i==raddr k (!=0), rdata k SHALL equal wdata_i and rbusy k SHALL be 0 in that cycle.
REQ-027 If BYPASS=0, a read SHALL return the old value until the edge after the write.
REQ-028 rbusy k SHALL equal busy[raddr k], subject to REQ-026; allocs SHALL become visible on the next cycle only.
REQ-029 pending_cnt_o SHALL be a registered count equal to the popcount of busy bits; it SHALL update in the same edge as the busy bits and stay in 0..NREG-1.
REQ-030 Writes to a non-busy register SHALL still update data with no error; pending_cnt_o SHALL never underflow.
REQ-031 Multiple read ports SHALL be independent; identical addresses SHALL return identical data.

Reset
REQ-032 rst=1 at an edge SHALL clear all registers to 0, clear all busy bits and set pending_cnt_o to 0; rst SHALL override wen_i, alloc_i and flush_i.
REQ-033 After reset, rdata_o SHALL be all 0, rbusy_o SHALL be 0 and any_busy_o SHALL be 0.
REQ-034 Reset asserted mid-operation with pending allocs SHALL discard all pending state in one cycle.

Verification
REQ-035 Reset, then write 0xDEADBEEF to r5; next cycle read r5 on port 0 and r0 on port 1 -> 0xDEADBEEF and 0.
REQ-036 BYPASS=1: write r3=0x12345678 while reading r3 -> rdata=0x12345678 and rbusy=0 in the same cycle; with BYPASS=0 -> old value 0.
REQ-037 Alloc r7 -> next cycle rbusy=1 and cnt=1; writeback r7 -> next cycle rbusy=0 and cnt=0.
REQ-038 Alloc and writeback r9 in the same cycle -> data updated, busy=1, cnt=1.
REQ-039 Alloc r1, r2, r0 on successive cycles -> cnt=2; flush together with alloc r4 -> cnt=0.
REQ-040 Alloc r2 and write r6=5, then rst -> all reads 0, rbusy=0, cnt=0, any_busy=0.
